// File: rtl/spi_flash_boot_loader.sv
// Copies WORDS 32-bit words from SPI NOR flash (single READ 0x03, mode 0) into program SRAM, little-endian packed.
// One SRAM write per word, overlapped with shifting of the next word; done is sticky until rst_i.
module spi_flash_boot_loader #(
    parameter int          SRAM_ADDR_WIDTH = 11,
    parameter logic [23:0] FLASH_BASE      = 24'h000000,
    parameter int          WORDS           = 2048,
    parameter int          CLK_DIV         = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    output logic                       spi_cs_n_o,
    output logic                       spi_sck_o,
    output logic                       spi_mosi_o,
    input  logic                       spi_miso_i,
    output logic                       mem_we_o,
    output logic [SRAM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]                mem_wdata_o,
    output logic [3:0]                 mem_wstrb_o,
    output logic                       done_o
);

    localparam int                   DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SRAM_ADDR_WIDTH:0] LAST_WORD = (SRAM_ADDR_WIDTH + 1)'(WORDS - 1);
    localparam logic [31:0]          HDR       = {8'h03, FLASH_BASE};

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_FINISH, S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic                       sck_q, sck_d;
    logic [4:0]                 bit_q, bit_d;
    logic [31:0]                hdr_q, hdr_d;
    logic [6:0]                 byte_q, byte_d;
    logic [31:0]                word_q, word_d;
    logic                       last_q, last_d;
    logic                       pend_q, pend_d;
    logic                       we_q, we_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [SRAM_ADDR_WIDTH:0]   wcnt_q, wcnt_d;

    logic active, tick, rise, fall;

    assign active = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA);
    assign tick   = active && (div_q == DIV_LAST);
    assign rise   = tick && !sck_q;
    assign fall   = tick && sck_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        spi_cs_n_o = 1'b1;
        spi_mosi_o = 1'b0;
        done_o     = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_CMD;
            S_CMD: begin
                spi_cs_n_o = 1'b0;
                spi_mosi_o = hdr_q[31];
                if (fall && bit_q == 5'd7) state_d = S_ADDR;
            end
            S_ADDR: begin
                spi_cs_n_o = 1'b0;
                spi_mosi_o = hdr_q[31];
                if (fall && bit_q == 5'd31) state_d = S_DATA;
            end
            S_DATA: begin
                spi_cs_n_o = 1'b0;
                if (fall && last_q) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_DONE;
            S_DONE:   done_o  = 1'b1;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        div_d   = div_q;
        sck_d   = sck_q;
        bit_d   = bit_q;
        hdr_d   = hdr_q;
        byte_d  = byte_q;
        word_d  = word_q;
        last_d  = last_q;
        pend_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wcnt_d  = wcnt_q;

        if (active) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) sck_d = ~sck_q;
        end else begin
            div_d = '0;
            sck_d = 1'b0;
        end

        if (state_q == S_IDLE) hdr_d = HDR;

        // Header bits advance on falling edges so MOSI is settled a full low phase before each rise.
        if (fall && state_q != S_DATA) begin
            hdr_d = {hdr_q[30:0], 1'b0};
            bit_d = bit_q + 5'd1;
        end

        if (rise && state_q == S_DATA) begin
            bit_d  = bit_q + 5'd1;
            byte_d = {byte_q[5:0], spi_miso_i};
            if (bit_q[2:0] == 3'd7) word_d[{bit_q[4:3], 3'b000} +: 8] = {byte_q, spi_miso_i};
            if (bit_q == 5'd31) begin
                pend_d = 1'b1;
                if (wcnt_q == LAST_WORD) last_d = 1'b1;
            end
        end

        // Write is issued the cycle after the word completes, independent of FSM state.
        if (pend_q) begin
            we_d    = 1'b1;
            addr_d  = wcnt_q[SRAM_ADDR_WIDTH-1:0];
            wdata_d = word_q;
            wcnt_d  = wcnt_q + (SRAM_ADDR_WIDTH + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q   <= '0;
            sck_q   <= 1'b0;
            bit_q   <= '0;
            hdr_q   <= HDR;
            byte_q  <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wcnt_q  <= '0;
        end else begin
            div_q   <= div_d;
            sck_q   <= sck_d;
            bit_q   <= bit_d;
            hdr_q   <= hdr_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign spi_sck_o   = sck_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = {4{we_q}};

endmodule

// File: doc/spi_flash_boot_loader.md
# spi_flash_boot_loader

Boot-time copier that sits directly upstream of the on-chip program SRAM. After reset it streams a fixed-length image out of the external SPI NOR flash with one continuous READ (0x03) transaction. It packs the bytes little-endian into 32-bit words and writes them through the SRAM byte-lane write port. It then raises `done`, which the top level uses to hold the CPU in reset until the image is in place.

## Interface
Parameters:
- `SRAM_ADDR_WIDTH`, 11: SRAM word-address width; capacity is 2^SRAM_ADDR_WIDTH words.
- `FLASH_BASE`, 24'h000000: flash byte address of the first image byte.
- `WORDS`, 2048: number of 32-bit words to copy; legal range 1..2^SRAM_ADDR_WIDTH.
- `CLK_DIV`, 2: SCK half-period in `clk` cycles; must be ≥1.

Ports:
- `clk` in 1: single system clock.
- `rst` in 1: reset is synchronous and active-high.
- `spi_cs_n` out 1: flash chip select, active low.
- `spi_sck` out 1: SPI clock, mode 0, idles low.
- `spi_mosi` out 1: command/address to flash, MSB first.
- `spi_miso` in 1: data from flash.
- `mem_we` out 1: single-cycle SRAM write strobe.
- `mem_addr` out SRAM_ADDR_WIDTH: SRAM word address.
- `mem_wdata` out 32: packed word.
- `mem_wstrb` out 4: byte enables; 4'hF while `mem_we` is high, 4'h0 otherwise.
- `done` out 1: copy complete; sticky until `rst`.

## Operation
- States:
  - IDLE: one cycle after reset release.
  - CMD: 8 bits of 0x03.
  - ADDR: 24 bits of FLASH_BASE, MSB first.
  - DATA: 32×WORDS bits.
  - FINISH: release CS.
  - DONE: terminal.
- Transitions:
  - IDLE→CMD unconditionally.
  - CMD→ADDR after the 8th SCK falling edge.
  - ADDR→DATA after the 24th falling edge.
  - DATA→FINISH after the sampling edge of the final bit, once SCK is back low.
  - FINISH→DONE after one cycle.
  - DONE holds until `rst`.
- SPI, mode 0:
  - `spi_cs_n` is low from CMD through DATA inclusive, with no deassertion between bytes.
  - MOSI changes only while SCK is low, and at least CLK_DIV cycles before each rising edge.
  - MISO is sampled on the `clk` edge that drives SCK high.
  - MOSI is 0 during DATA.
- Byte assembly:
  - Each byte is shifted in MSB first.
  - Byte k of a word (k=0..3, in flash order) lands in bits [8k+7:8k], so flash bytes b0 b1 b2 b3 form {b3,b2,b1,b0}.
- SRAM writes:
  - After the 32nd data bit of a word is sampled, `mem_we` pulses for exactly one cycle.
  - `mem_addr` = word index (0..WORDS-1), `mem_wdata` = packed word, `mem_wstrb` = 4'hF.
  - `mem_addr` and `mem_wdata` are stable during the pulse.
  - SCK does not stall for writes; the next word's shifting overlaps the write.
- Word counter:
  - Width is SRAM_ADDR_WIDTH+1, so WORDS = 2^SRAM_ADDR_WIDTH terminates correctly without wrap.
  - Exactly WORDS writes occur, each address once, in ascending order.
- Reset:
  - `rst` high at any point, mid-transaction included, forces the reset values below on the next `clk` edge and aborts the transfer.
  - After release, the copy restarts from CMD and word 0.

## Timing
- Reset values: `spi_cs_n`=1, `spi_sck`=0, `spi_mosi`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `done`=0.
- SCK: high and low phases are each exactly CLK_DIV `clk` cycles.
- SCK count: total rising edges = 32 + 32×WORDS.
- Write timing: `mem_we` rises 1 cycle after the sampling edge of each word's final bit.
- Completion:
  - `spi_cs_n` returns high no later than CLK_DIV+1 cycles after the final rising edge.
  - `done` rises 1 cycle after `spi_cs_n` goes high.
- Overall latency: `done` rises within 2×CLK_DIV×(32+32×WORDS)+CLK_DIV+4 cycles of `rst` deassertion.
- After `done`:
  - No further SCK edges or writes until `rst`.
  - `mem_we` stays 0 and `spi_cs_n` stays 1.

## Test plan
- Header: FLASH_BASE=24'h100000, CLK_DIV=2 -> MOSI bits sampled on the first 32 rising edges = 0x03,0x10,0x00,0x00; CS stays low throughout.
- Packing: flash model returns 11 22 33 44 55 66 77 88, WORDS=2 -> exactly two writes: addr 0 = 0x44332211, addr 1 = 0x88776655, wstrb 4'hF, each pulse 1 cycle; `done`=1 afterwards.
- Minimum length: WORDS=1 -> exactly 64 SCK rising edges, one write to addr 0, then CS high and `done` high; no further SCK activity over 1000 cycles.
- Clock shape: CLK_DIV=3 -> every SCK high and low phase is 3 cycles; MOSI never changes while SCK is high.
- Reset mid-copy: assert `rst` for 1 cycle during word 5 of WORDS=16 -> next cycle CS=1, SCK=0, `mem_we`=0, `done`=0; after release a fresh 0x03 command is issued, writes restart at addr 0, and all 16 words are correct.
- Full range: SRAM_ADDR_WIDTH=4, WORDS=16 -> 16 writes to addresses 0..15, each exactly once, with no write after addr 15; `done` stays high until `rst`.
